// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one CPU load/store becomes AR/R or AW/W/B traffic and one completion.
// Latency: 3 cycles accept-to-completion with a zero-wait responder; the request port stalls (req_ready=0) while busy.
module axi_lite_master #(
    parameter logic [3:0] ID = 4'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic [3:0]  rid,
    input  logic        rlast,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} state_t;

    state_t      state_q, state_d;
    logic        arvalid_q, arvalid_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] araddr_q, araddr_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        rd_err;

    // A read beat is bad on SLVERR/DECERR, a foreign ID, or a non-final beat.
    assign rd_err = rresp[1] | (rid != ID) | ~rlast;

    always_comb begin
        state_d      = state_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        araddr_d     = araddr_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    araddr_d = req_addr;
                    awaddr_d = req_addr;
                    wdata_d  = req_wdata;
                    wstrb_d  = req_wstrb;
                    if (req_wen) begin
                        state_d   = S_WR;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d = S_AR;
                    end
                end
            end
            S_AR: begin
                if (arready) state_d = S_R;
            end
            S_R: begin
                if (rvalid) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = rd_err;
                    resp_rdata_d = rd_err ? 32'h0 : rdata;
                    state_d      = S_IDLE;
                end
            end
            S_WR: begin
                // Fires in this cycle count, so a joint AW+W handshake goes straight to B.
                if (awvalid_q && awready) aw_done_d = 1'b1;
                if (wvalid_q && wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = S_B;
            end
            S_B: begin
                if (bvalid) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = bresp[1];
                    resp_rdata_d = 32'h0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        arvalid_d = (state_d == S_AR);
        awvalid_d = (state_d == S_WR) && !aw_done_d;
        wvalid_d  = (state_d == S_WR) && !w_done_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            arvalid_q    <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            araddr_q     <= 32'h0;
            awaddr_q     <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            arvalid_q    <= arvalid_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            araddr_q     <= araddr_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign rready     = (state_q == S_R);
    assign bready     = (state_q == S_B);
    assign arvalid    = arvalid_q;
    assign araddr     = araddr_q;
    assign arid       = ID;
    assign awvalid    = awvalid_q;
    assign awaddr     = awaddr_q;
    assign wvalid     = wvalid_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule
